// File: rtl/jtag_instruction_register_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_types_pkg
//  Description : Shared JTAG types: IR length, instruction opcodes and the
//                fixed capture pattern loaded into the IR low bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtag_types_pkg;

    // Instruction register length in bits.
    localparam int IR_LEN = 4;

    // Two LSBs forced into the IR on Capture-IR, as 1149.1 requires.
    localparam logic [1:0] CAPTURE_LSBS = 2'b01;

    // Opcodes seen by the instruction decoder. Unlisted encodings are still
    // legal values of this type; the decoder maps them to BYPASS.
    typedef enum logic [IR_LEN-1:0] {
        EXTEST         = 4'b0000,
        IDCODE         = 4'b0001,
        SAMPLE_PRELOAD = 4'b0010,
        AHB            = 4'b1000,
        BYPASS         = 4'b1111
    } instruction_t;

endpackage : jtag_types_pkg
`default_nettype wire

// File: rtl/jtag_instruction_register_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_instruction_register_if
//  Description : Bundle between the TAP controller (master) and the
//                instruction register (slave): state strobes, serial data,
//                captured status and the resulting instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jtag_instruction_register_if
    import jtag_types_pkg::*;
#(
    parameter int IR_WIDTH = IR_LEN
);

    logic                tlr_reset;
    logic                capture_ir;
    logic                shift_ir;
    logic                update_ir;
    logic                TDI;
    logic [IR_WIDTH-3:0] ir_status;

    logic                ir_tdo;
    instruction_t        parallel_out;
    logic                ir_len_err;

    // TAP controller side
    modport master (
        output tlr_reset,
        output capture_ir,
        output shift_ir,
        output update_ir,
        output TDI,
        output ir_status,
        input  ir_tdo,
        input  parallel_out,
        input  ir_len_err
    );

    // Instruction register side
    modport slave (
        input  tlr_reset,
        input  capture_ir,
        input  shift_ir,
        input  update_ir,
        input  TDI,
        input  ir_status,
        output ir_tdo,
        output parallel_out,
        output ir_len_err
    );

endinterface : jtag_instruction_register_if
`default_nettype wire

// File: rtl/jtag_instruction_register_shift_counter.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_ir_shift_counter
//  Description : Counts Shift-IR cycles since the last capture, saturating at
//                MAX_COUNT+1 so any overlong shift stays distinguishable from
//                an exact one. o_length_ok flags an exact MAX_COUNT shifts.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_ir_shift_counter #(
    parameter int MAX_COUNT = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_inc,
    output logic      o_length_ok
);

    localparam int            c_CW      = $clog2(MAX_COUNT + 2);
    localparam logic [c_CW-1:0] c_TARGET = c_CW'(MAX_COUNT);
    localparam logic [c_CW-1:0] c_SAT    = c_CW'(MAX_COUNT + 1);

    logic [c_CW-1:0] r_count;

    // Clear wins over increment; increment stops at the saturation value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_SAT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_length_ok = (r_count == c_TARGET);

endmodule : jtag_ir_shift_counter
`default_nettype wire

// File: rtl/jtag_instruction_register.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_instruction_register
//  Description : 1149.1 instruction register. Serial shift stage driven by
//                the TAP strobes, plus a shadow stage that holds the current
//                instruction steady for the decoder while a new opcode is
//                being shifted in.
//                Optional build macro JTAG_IR_LENGTH_CHECK_EN: rejects any
//                update whose shift count is not exactly IR_WIDTH, loading
//                BYPASS and raising ir_len_err instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_instruction_register
    import jtag_types_pkg::*;
#(
    // Must equal IR_LEN: the shadow stage is typed instruction_t.
    parameter int           IR_WIDTH    = IR_LEN,
    parameter instruction_t RESET_INSTR = IDCODE
) (
    input  wire logic                  TCK,
    input  wire logic                  TRST,
    jtag_instruction_register_if.slave ir_bus
);

    localparam logic [IR_WIDTH-1:0] c_SHIFT_RESET =
        {{(IR_WIDTH-2){1'b0}}, CAPTURE_LSBS};

    logic [IR_WIDTH-1:0] r_shift_reg;
    instruction_t        r_parallel;
    logic                w_len_ok;
    logic                w_do_tlr;
    logic                w_do_capture;
    logic                w_do_shift;
    logic                w_do_update;

    // Strobe priority: tlr_reset > capture_ir > shift_ir > update_ir.
    always_comb begin
        w_do_tlr     = ir_bus.tlr_reset;
        w_do_capture = ir_bus.capture_ir & ~ir_bus.tlr_reset;
        w_do_shift   = ir_bus.shift_ir & ~ir_bus.capture_ir & ~ir_bus.tlr_reset;
        w_do_update  = ir_bus.update_ir & ~ir_bus.shift_ir
                     & ~ir_bus.capture_ir & ~ir_bus.tlr_reset;
    end

    // Shift stage: capture status, then shift LSB-first with TDI into the MSB.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_shift_reg <= c_SHIFT_RESET;
        end else if (w_do_tlr) begin
            r_shift_reg <= c_SHIFT_RESET;
        end else if (w_do_capture) begin
            r_shift_reg <= {ir_bus.ir_status, CAPTURE_LSBS};
        end else if (w_do_shift) begin
            r_shift_reg <= {ir_bus.TDI, r_shift_reg[IR_WIDTH-1:1]};
        end
    end

`ifdef JTAG_IR_LENGTH_CHECK_EN
    logic r_len_err;

    jtag_ir_shift_counter #(
        .MAX_COUNT (IR_WIDTH)
    ) u_shift_counter (
        .clk         (TCK),
        .rst         (TRST),
        .i_clear     (w_do_tlr | w_do_capture),
        .i_inc       (w_do_shift),
        .o_length_ok (w_len_ok)
    );

    // Error flag reflects the most recent update; cleared by any reset.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_len_err <= 1'b0;
        end else if (w_do_tlr) begin
            r_len_err <= 1'b0;
        end else if (w_do_update) begin
            r_len_err <= ~w_len_ok;
        end
    end

    assign ir_bus.ir_len_err = r_len_err;
`else
    // Without the check every shift length is accepted.
    assign w_len_ok          = 1'b1;
    assign ir_bus.ir_len_err = 1'b0;
`endif

    // Shadow stage: only reset and update may change the decoder's input.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            r_parallel <= RESET_INSTR;
        end else if (w_do_tlr) begin
            r_parallel <= RESET_INSTR;
        end else if (w_do_update) begin
            r_parallel <= w_len_ok ? instruction_t'(r_shift_reg) : BYPASS;
        end
    end

    assign ir_bus.ir_tdo       = r_shift_reg[0];
    assign ir_bus.parallel_out = r_parallel;

endmodule : jtag_instruction_register
`default_nettype wire

// File: tb/tb_jtag_instruction_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_instruction_register
//  Description : Directed self-checking bench for jtag_instruction_register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_instruction_register;
    import jtag_types_pkg::*;

    logic TCK;
    logic TRST;
    int   vectors;
    int   miscompares;

    jtag_instruction_register_if #(.IR_WIDTH(4)) ir_bus ();

    jtag_instruction_register #(
        .IR_WIDTH    (4),
        .RESET_INSTR (IDCODE)
    ) dut (
        .TCK    (TCK),
        .TRST   (TRST),
        .ir_bus (ir_bus.slave)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive strobes/TDI, then advance one TCK edge and settle 1 time unit.
    task automatic step(input logic tlr, input logic cap, input logic sh,
                        input logic up, input logic tdi);
        ir_bus.tlr_reset  = tlr;
        ir_bus.capture_ir = cap;
        ir_bus.shift_ir   = sh;
        ir_bus.update_ir  = up;
        ir_bus.TDI        = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic idle();
        ir_bus.tlr_reset  = 1'b0;
        ir_bus.capture_ir = 1'b0;
        ir_bus.shift_ir   = 1'b0;
        ir_bus.update_ir  = 1'b0;
        ir_bus.TDI        = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        TRST        = 1'b0;
        idle();
        ir_bus.ir_status = 2'b10;

        // Power-on reset, checked before any TCK edge
        #2 TRST = 1'b1;
        #2;
        check("por_parallel", 8'(ir_bus.parallel_out), 8'h1);
        check("por_tdo",      8'(ir_bus.ir_tdo),       8'h1);
        check("por_len_err",  8'(ir_bus.ir_len_err),   8'h0);
        #3 TRST = 1'b0;

        // Capture status 10 -> 1001, shift out LSB first: 1,0,0,1
        step(0, 1, 0, 0, 0);
        check("cap_tdo0", 8'(ir_bus.ir_tdo), 8'h1);
        step(0, 0, 1, 0, 0);
        check("shf_tdo1", 8'(ir_bus.ir_tdo), 8'h0);
        step(0, 0, 1, 0, 0);
        check("shf_tdo2", 8'(ir_bus.ir_tdo), 8'h0);
        step(0, 0, 1, 0, 0);
        check("shf_tdo3", 8'(ir_bus.ir_tdo), 8'h1);
        check("shf_parallel_hold", 8'(ir_bus.parallel_out), 8'h1);

        // Load AHB: capture, shift 0,0,0,1, update
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("ahb_shift_hold", 8'(ir_bus.parallel_out), 8'h1);
        step(0, 0, 1, 0, 1);
        check("ahb_shift_hold2", 8'(ir_bus.parallel_out), 8'h1);
        ir_bus.shift_ir  = 1'b0;
        ir_bus.update_ir = 1'b1;
        #1;
        check("ahb_pre_edge", 8'(ir_bus.parallel_out), 8'h1);
        step(0, 0, 0, 1, 0);
        check("ahb_parallel", 8'(ir_bus.parallel_out), 8'h8);
        check("ahb_len_err",  8'(ir_bus.ir_len_err),   8'h0);
        step(0, 0, 0, 0, 0);
        check("idle_hold", 8'(ir_bus.parallel_out), 8'h8);

        // TRST mid-shift: capture 1001, shift 1,1 -> 1110 (tdo 0), then reset
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        check("mid_tdo_pre", 8'(ir_bus.ir_tdo), 8'h0);
        TRST = 1'b1;
        #1;
        check("mid_rst_parallel", 8'(ir_bus.parallel_out), 8'h1);
        check("mid_rst_tdo",      8'(ir_bus.ir_tdo),       8'h1);
        check("mid_rst_len_err",  8'(ir_bus.ir_len_err),   8'h0);
        idle();
        #2 TRST = 1'b0;

        // Capture and shift together: capture wins (11 -> 1101), then update
        ir_bus.ir_status = 2'b11;
        step(0, 1, 1, 0, 0);
        check("prio_cap_tdo", 8'(ir_bus.ir_tdo), 8'h1);
        step(0, 0, 0, 1, 0);
`ifdef JTAG_IR_LENGTH_CHECK_EN
        check("prio_zero_shift_parallel", 8'(ir_bus.parallel_out), 8'hF);
        check("prio_zero_shift_err",      8'(ir_bus.ir_len_err),   8'h1);
`else
        check("prio_cap_parallel", 8'(ir_bus.parallel_out), 8'hD);
        check("prio_cap_err",      8'(ir_bus.ir_len_err),   8'h0);
`endif

        // Load AHB again (from 1101: 0,0,0,1 -> 1000), then tlr_reset + update
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0);
        check("ahb2_parallel", 8'(ir_bus.parallel_out), 8'h8);
        step(1, 0, 0, 1, 0);
        check("tlr_parallel", 8'(ir_bus.parallel_out), 8'h1);
        check("tlr_tdo",      8'(ir_bus.ir_tdo),       8'h1);
        check("tlr_len_err",  8'(ir_bus.ir_len_err),   8'h0);

        // Five-bit shift 1,0,1,0,0 from 1101 -> 0010
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
`ifdef JTAG_IR_LENGTH_CHECK_EN
        check("len5_parallel", 8'(ir_bus.parallel_out), 8'hF);
        check("len5_err",      8'(ir_bus.ir_len_err),   8'h1);
        step(0, 0, 0, 0, 0);
        check("len5_err_sticky", 8'(ir_bus.ir_len_err), 8'h1);
`else
        check("len5_parallel", 8'(ir_bus.parallel_out), 8'h2);
        check("len5_err",      8'(ir_bus.ir_len_err),   8'h0);
`endif

        // Exact four-bit SAMPLE_PRELOAD: from 1101 shift 0,1,0,0 -> 0010
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        check("sp_parallel", 8'(ir_bus.parallel_out), 8'h2);
        check("sp_len_err",  8'(ir_bus.ir_len_err),   8'h0);

        // EXTEST: capture 1101, shift 0,0,0,0 -> 0000
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("ext_tdo", 8'(ir_bus.ir_tdo), 8'h0);
        step(0, 0, 0, 1, 0);
        check("ext_parallel", 8'(ir_bus.parallel_out), 8'h0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_jtag_instruction_register
`default_nettype wire
